// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter that lets several Wishbone managers share a single
// peripheral bus. Only the granted manager is forwarded to the peripheral.
// Every ownership change is followed by a one-cycle bus gap. A strobe that
// the peripheral leaves unacknowledged for too long is terminated with an
// error acknowledge.
module wb_rr_arbiter #(
    parameter int NUM_MANAGERS = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic [32*NUM_MANAGERS-1:0]  A_ADR_I,
    input  logic [32*NUM_MANAGERS-1:0]  A_DAT_I,
    input  logic [4*NUM_MANAGERS-1:0]   A_SEL_I,
    input  logic [NUM_MANAGERS-1:0]     A_WE_I,
    input  logic [NUM_MANAGERS-1:0]     A_STB_I,
    input  logic [NUM_MANAGERS-1:0]     A_CYC_I,
    output logic [32*NUM_MANAGERS-1:0]  A_DAT_O,
    output logic [NUM_MANAGERS-1:0]     A_ACK_O,
    output logic [NUM_MANAGERS-1:0]     A_ERR_O,
    input  logic [31:0]                 DAT_I,
    input  logic                        ACK_I,
    output logic [31:0]                 ADR_O,
    output logic [31:0]                 DAT_O,
    output logic [3:0]                  SEL_O,
    output logic                        WE_O,
    output logic                        STB_O,
    output logic                        CYC_O,
    output logic [NUM_MANAGERS-1:0]     GNT_O
);

    localparam int          IDX_W    = (NUM_MANAGERS > 1) ? $clog2(NUM_MANAGERS) : 1;
    localparam logic [15:0] TMO      = 16'(TIMEOUT);
    localparam logic [31:0] ERR_DATA = 32'hBADB_BADB;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        HOLDOFF
    } state_e;

    state_e                  state_q, state_d;
    logic [NUM_MANAGERS-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;   // index of the current owner
    logic [IDX_W-1:0]        ptr_q, ptr_d;   // last owner; search starts just above it
    logic [15:0]             cnt_q, cnt_d;   // cycles the current strobe has waited

    logic                    found;
    logic [IDX_W-1:0]        pick_idx;
    logic [IDX_W-1:0]        cand;
    logic                    granted;
    logic                    stb_raw;
    logic                    timeout_hit;

    // Per-manager views of the packed request buses.
    logic [31:0] adr_m [NUM_MANAGERS];
    logic [31:0] dat_m [NUM_MANAGERS];
    logic [3:0]  sel_m [NUM_MANAGERS];

    // Split the packed manager buses into per-manager words.
    always_comb begin : unpack_managers
        for (int m = 0; m < NUM_MANAGERS; m++) begin
            adr_m[m] = A_ADR_I[32*m +: 32];
            dat_m[m] = A_DAT_I[32*m +: 32];
            sel_m[m] = A_SEL_I[4*m +: 4];
        end
    end

    // Search upward from ptr+1 (wrapping) for the first manager holding CYC.
    always_comb begin : pick_next
        // NOTE: every variable written here gets a default before any branch,
        // otherwise paths that skip an assignment infer a latch.
        found    = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = 1; i <= NUM_MANAGERS; i++) begin
            cand = IDX_W'((int'(ptr_q) + i) % NUM_MANAGERS);
            if (!found && A_CYC_I[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign granted     = (state_q == GRANT);
    assign stb_raw     = granted & A_STB_I[idx_q];
    // Acknowledge wins over the timeout when both land in the same cycle.
    assign timeout_hit = stb_raw & ~ACK_I & (cnt_q == TMO);

    // Next-state, grant, pointer and timeout-counter update.
    always_comb begin : fsm_next
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    idx_d   = pick_idx;
                    gnt_d   = NUM_MANAGERS'(1) << pick_idx;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (!A_CYC_I[idx_q]) begin
                    // Owner released the bus: remember it for fairness and
                    // drop everything for one gap cycle.
                    state_d = HOLDOFF;
                    gnt_d   = '0;
                    ptr_d   = idx_q;
                    cnt_d   = '0;
                end else if (ACK_I || !stb_raw || timeout_hit) begin
                    cnt_d = '0;
                end else if (cnt_q != TMO) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HOLDOFF: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Forward the owner to the peripheral and route the response back to it.
    always_comb begin : route_bus
        ADR_O   = '0;
        DAT_O   = '0;
        SEL_O   = '0;
        WE_O    = 1'b0;
        STB_O   = 1'b0;
        CYC_O   = 1'b0;
        A_DAT_O = '0;
        A_ACK_O = '0;
        A_ERR_O = '0;
        if (granted) begin
            ADR_O = adr_m[idx_q];
            DAT_O = dat_m[idx_q];
            SEL_O = sel_m[idx_q];
            WE_O  = A_WE_I[idx_q];
            STB_O = stb_raw & ~timeout_hit;
            CYC_O = A_CYC_I[idx_q];
        end
        // gnt_q is one-hot only while in GRANT, so IDLE and HOLDOFF hide ACK_I.
        for (int m = 0; m < NUM_MANAGERS; m++) begin
            if (gnt_q[m]) begin
                A_ACK_O[m]          = ACK_I | timeout_hit;
                A_ERR_O[m]          = timeout_hit;
                A_DAT_O[32*m +: 32] = timeout_hit ? ERR_DATA : DAT_I;
            end
        end
    end

    assign GNT_O = gnt_q;

    // State registers; reset parks the pointer on the last manager so that
    // manager 0 wins the first arbitration.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= IDX_W'(NUM_MANAGERS - 1);
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 Parameter NUM_MANAGERS, default 2, number of Wishbone managers sharing the peripheral bus (legal range 1..8).
REQ-002 Parameter TIMEOUT, default 255, peripheral-ACK cycles allowed per strobe before forced termination (legal range 1..65535).
REQ-003 CLK  input  1  bus clock; all state updates on rising edge.
REQ-004 nRST  input  1  reset, asynchronous, active-low.
REQ-005 A_ADR_I  input  32*NUM_MANAGERS  manager addresses, manager m in bits [32m+:32]; A_DAT_I is identical in width and packing.
REQ-006 A_SEL_I  input  4*NUM_MANAGERS  manager byte selects.
REQ-007 A_WE_I, A_STB_I, A_CYC_I  input  NUM_MANAGERS each  manager write-enable, strobe, cycle.
REQ-008 A_DAT_O  output  32*NUM_MANAGERS  read data returned to managers.
REQ-009 A_ACK_O  output  NUM_MANAGERS  per-manager acknowledge.
REQ-010 A_ERR_O  output  NUM_MANAGERS  per-manager timeout indication.
REQ-011 DAT_I  input  32  peripheral read data; ACK_I  input  1  peripheral acknowledge.
REQ-012 ADR_O  output  32, DAT_O  output  32, SEL_O  output  4, WE_O, STB_O, CYC_O  output  1 each  forwarded signals to peripheral bus.
REQ-013 GNT_O  output  NUM_MANAGERS  one-hot current grant, for debug/LA observation.

Function
REQ-014 FSM states: IDLE, GRANT, HOLDOFF; state, grant vector, round-robin pointer and timeout counter are registers.
REQ-015 IDLE: if any A_CYC_I bit is high, grant the first requester searching upward (modulo NUM_MANAGERS) from pointer+1, load GNT_O one-hot, go to GRANT; otherwise remain in IDLE.
REQ-016 Grant latency: exactly one cycle from A_CYC_I sampled high in IDLE to CYC_O high.
REQ-017 GRANT: ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O combinationally equal the granted manager's inputs; non-granted managers see A_ACK_O=0, A_ERR_O=0, A_DAT_O=0.
REQ-018 GRANT: ACK_I and DAT_I are routed combinationally to the granted manager's A_ACK_O and A_DAT_O slice (zero added latency).
REQ-019 Grant is held for the manager's whole CYC (multiple strobes/burst); no preemption by other requesters.
REQ-020 GRANT -> HOLDOFF when the granted manager's A_CYC_I is sampled low; pointer updates to the granted index on that edge.
REQ-021 HOLDOFF lasts exactly one cycle with all peripheral outputs 0 and GNT_O=0, then IDLE; this guarantees a one-cycle bus gap between owners.
REQ-022 Timeout counter: cleared on entering GRANT and on every cycle with ACK_I=1 or STB_O=0; increments each cycle STB_O=1 and ACK_I=0; saturates at TIMEOUT.
REQ-023 When counter equals TIMEOUT with ACK_I still 0: assert granted A_ERR_O and A_ACK_O for one cycle with A_DAT_O=32'hBADB_BADB, force STB_O=0 that cycle, clear counter; grant retained.
REQ-024 ACK_I arriving in the same cycle the counter reaches TIMEOUT: normal acknowledge wins, no A_ERR_O.
REQ-025 ACK_I while in IDLE or HOLDOFF is ignored; no manager sees an acknowledge.
REQ-026 NUM_MANAGERS=1: same FSM, pointer is constant 0, HOLDOFF still inserted.
REQ-027 All outputs other than the combinational forwarding paths of REQ-017/018/023 are driven from registers.

Reset
REQ-028 nRST low asynchronously forces IDLE, GNT_O=0, pointer=NUM_MANAGERS-1 (so manager 0 wins first), counter=0.
REQ-029 During reset all outputs are 0: CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O, A_ACK_O, A_ERR_O, A_DAT_O.
REQ-030 Reset asserted mid-transaction aborts it immediately; no acknowledge is produced for the aborted cycle.

Verification
REQ-031 Reset, then manager 0 single read of 0x3000_0004, peripheral ACK after 2 cycles with DAT_I=0x1234_5678 -> CYC_O high 1 cycle after A_CYC_I; A_ACK_O[0]=1 and A_DAT_O[0]=0x1234_5678 in the ACK cycle; HOLDOFF then IDLE.
REQ-032 Managers 0 and 1 assert CYC in the same cycle, each performs 3 transactions -> grants alternate 0,1,0,1,0,1, with a one-cycle CYC_O gap between owners.
REQ-033 Manager 1 holds CYC for a 4-beat write burst while manager 0 requests -> manager 0 is not granted until HOLDOFF after burst end; all 4 beats forwarded to manager 1 only.
REQ-034 TIMEOUT=8, peripheral never ACKs -> in the 9th strobe cycle A_ERR_O=A_ACK_O=1 for one cycle, A_DAT_O=0xBADB_BADB, STB_O low that cycle.
REQ-035 ACK_I in exactly the cycle the counter hits TIMEOUT -> normal ACK with DAT_I, A_ERR_O stays 0.
REQ-036 nRST pulsed low during a pending read -> all outputs 0 without waiting for a clock edge; after release manager 0 is granted first.
